flag_branch_unit: RTL

Consumer-side counterpart of the 16-bit ALU. It captures the ALU's N/Z/V outputs into the architectural flag register and resolves conditional branches against those flags. It tracks outstanding flag-setting instructions so a branch waits until its flags are final, then reports a registered taken/target result. It sits at the EX/MEM boundary of the 5-stage pipeline, between the ALU and PC-select logic.

---
 rtl/flag_branch_unit.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/flag_branch_unit.sv
// flag_branch_unit: architectural N/Z/V flag register plus conditional branch
// resolver. Tracks outstanding flag writers so a branch resolves only once its
// flags are final, then presents a registered taken/target result.
//
// Branch handshake: a branch transfers in any cycle where
// br_valid & br_ready & !stall & !flush are all high. br_ready is high exactly
// when the FSM is IDLE; the result appears later as a one-state br_done pulse
// (held while stall is high).
module flag_branch_unit #(
  parameter int PC_WIDTH  = 16,
  parameter int CNT_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_valid,
  input  logic [3:0]           alu_op,
  input  logic                 alu_N,
  input  logic                 alu_Z,
  input  logic                 alu_V,
  input  logic                 fw_issue,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 br_valid,
  output logic                 br_ready,
  input  logic [2:0]           br_cond,
  input  logic [8:0]           br_offset,
  input  logic [PC_WIDTH-1:0]  br_pc_plus1,
  output logic [2:0]           flags_out,
  output logic                 br_done,
  output logic                 br_taken,
  output logic [PC_WIDTH-1:0]  br_target,
  output logic                 pend_err,
  output logic [1:0]           state_dbg,
  output logic [CNT_WIDTH-1:0] pend_cnt_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] PEND_MAX = {CNT_WIDTH{1'b1}};

  state_t               state_q, state_next;
  logic [2:0]           flags_q, flags_next;
  logic [CNT_WIDTH-1:0] pend_q, pend_next;
  logic                 err_q, err_set;
  logic [2:0]           cond_q;
  logic [8:0]           off_q;
  logic [PC_WIDTH-1:0]  pc_q;
  logic                 taken_q;
  logic [PC_WIDTH-1:0]  target_q;
  logic                 wr;
  logic                 capture, load_result;
  logic [2:0]           ev_cond;
  logic [8:0]           ev_off;
  logic [PC_WIDTH-1:0]  ev_pc;
  logic                 ev_taken;
  logic [PC_WIDTH-1:0]  ev_target;

  // Flags are {N,Z,V}.
  function automatic logic cond_true(input logic [2:0] c, input logic [2:0] f);
    logic n, z, v;
    n = f[2];
    z = f[1];
    v = f[0];
    case (c)
      3'b000:  cond_true = !z;
      3'b001:  cond_true = z;
      3'b010:  cond_true = !z && !n;
      3'b011:  cond_true = n;
      3'b100:  cond_true = z || !n;
      3'b101:  cond_true = n || z;
      3'b110:  cond_true = v;
      default: cond_true = 1'b1;
    endcase
  endfunction

  // Flag write with forwarding: ADD/SUB (op[1]=0) write all three, NAND/XOR only Z.
  always_comb begin
    wr         = alu_valid && (alu_op[3:2] == 2'b00);
    flags_next = flags_q;
    if (wr) begin
      flags_next[1] = alu_Z;
      if (!alu_op[1]) begin
        flags_next[2] = alu_N;
        flags_next[0] = alu_V;
      end
    end
  end

  // Outstanding flag-writer count; saturates and flags an error at either end.
  always_comb begin
    pend_next = pend_q;
    err_set   = 1'b0;
    if (flush) begin
      pend_next = '0;
    end else if (fw_issue && !wr) begin
      if (pend_q == PEND_MAX) err_set = 1'b1;
      else                    pend_next = pend_q + 1'b1;
    end else if (wr && !fw_issue) begin
      if (pend_q == '0) err_set = 1'b1;
      else              pend_next = pend_q - 1'b1;
    end
  end

  // Branch evaluation: live inputs when accepting in IDLE, latched operands in WAIT.
  always_comb begin
    ev_cond   = (state_q == IDLE) ? br_cond     : cond_q;
    ev_off    = (state_q == IDLE) ? br_offset   : off_q;
    ev_pc     = (state_q == IDLE) ? br_pc_plus1 : pc_q;
    ev_taken  = cond_true(ev_cond, flags_next);
    ev_target = ev_taken ? ev_pc + {{(PC_WIDTH-9){ev_off[8]}}, ev_off} : ev_pc;
  end

  // Next-state logic; flush overrides everything except reset.
  always_comb begin
    state_next  = state_q;
    capture     = 1'b0;
    load_result = 1'b0;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (br_valid && !stall) begin
            capture = 1'b1;
            if (pend_next == '0) begin
              state_next  = DONE;
              load_result = 1'b1;
            end else begin
              state_next = WAIT;
            end
          end
        end
        WAIT: begin
          if (pend_next == '0 && !stall) begin
            state_next  = DONE;
            load_result = 1'b1;
          end
        end
        DONE: begin
          if (!stall) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State, flag, counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      flags_q  <= 3'b000;
      pend_q   <= '0;
      err_q    <= 1'b0;
      cond_q   <= 3'b000;
      off_q    <= 9'd0;
      pc_q     <= '0;
      taken_q  <= 1'b0;
      target_q <= '0;
    end else begin
      state_q <= state_next;
      flags_q <= flags_next;
      pend_q  <= pend_next;
      if (err_set) err_q <= 1'b1;
      if (capture) begin
        cond_q <= br_cond;
        off_q  <= br_offset;
        pc_q   <= br_pc_plus1;
      end
      if (load_result) begin
        taken_q  <= ev_taken;
        target_q <= ev_target;
      end
    end
  end

  // Output mapping.
  always_comb begin
    br_ready     = (state_q == IDLE);
    br_done      = (state_q == DONE);
    flags_out    = flags_q;
    br_taken     = taken_q;
    br_target    = target_q;
    pend_err     = err_q;
    state_dbg    = state_q;
    pend_cnt_dbg = pend_q;
  end

endmodule
